// File: rtl/escalonador_quantum.sv
// Quantum-based preemption scheduler: counts user-mode instruction cycles and traps to the kernel on expiry or halt.
// Optional build macro INT_STATS_EN adds a saturating clock-interrupt counter on ContagemInterrupcoes.
module escalonador_quantum #(
  parameter int                  PC_WIDTH      = 11,
  parameter int                  QUANTUM_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] KERNEL_LIMIT  = PC_WIDTH'(64)
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Halt,
  input  logic                     SetClock,
  input  logic [QUANTUM_WIDTH-1:0] TempoQuantum,
  input  logic                     GetInterruption,
  input  logic [PC_WIDTH-1:0]      PCAtual,
  input  logic [PC_WIDTH-1:0]      PCProximo,
  output logic                     IntClk,
  output logic                     IntHalt,
  output logic [31:0]              QualInterrupcao,
  output logic [PC_WIDTH-1:0]      BufferPC,
  output logic                     Ativo,
  output logic [15:0]              ContagemInterrupcoes
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_CLOCK = 2'd1,
    CAUSE_HALT  = 2'd2
  } cause_t;

  state_t                  state, state_next;
  cause_t                  cause, cause_next;
  logic [QUANTUM_WIDTH-1:0] q, q_next;
  logic [QUANTUM_WIDTH-1:0] c, c_next;
  logic [PC_WIDTH-1:0]     buffer_pc, buffer_pc_next;
  logic                    int_clk, int_halt;
  logic                    user_code;

  assign user_code = (PCAtual >= KERNEL_LIMIT);

  // Priority inside IDLE/RUN: Halt, then SetClock, then quantum expiry.
  // SetClock always refreshes Q, so a same-cycle Halt or acknowledge reloads C from the new quantum.
  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can infer a latch.
    state_next     = state;
    cause_next     = cause;
    q_next         = SetClock ? TempoQuantum : q;
    c_next         = c;
    buffer_pc_next = buffer_pc;
    int_clk        = 1'b0;
    int_halt       = 1'b0;

    unique case (state)
      ST_IDLE, ST_RUN: begin
        if (Halt) begin
          int_halt   = 1'b1;
          cause_next = CAUSE_HALT;
          c_next     = q_next;
          state_next = ST_PEND;
        end else if (SetClock) begin
          if (TempoQuantum != '0) begin
            c_next     = TempoQuantum;
            state_next = ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end else if (state == ST_RUN && user_code) begin
          if (c == QUANTUM_WIDTH'(1)) begin
            int_clk        = 1'b1;
            buffer_pc_next = PCProximo;
            cause_next     = CAUSE_CLOCK;
            c_next         = q;
            state_next     = ST_PEND;
          end else if (c > QUANTUM_WIDTH'(1)) begin
            c_next = c - QUANTUM_WIDTH'(1);
          end
        end
      end
      ST_PEND: begin
        // Counter stays frozen while the kernel services the trap.
        if (Halt) begin
          int_halt   = 1'b1;
          cause_next = CAUSE_HALT;
        end else if (GetInterruption) begin
          cause_next = CAUSE_NONE;
          c_next     = q_next;
          state_next = (q_next != '0) ? ST_RUN : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!Reset) begin
      state     <= ST_IDLE;
      cause     <= CAUSE_NONE;
      q         <= '0;
      c         <= '0;
      buffer_pc <= '0;
    end else begin
      state     <= state_next;
      cause     <= cause_next;
      q         <= q_next;
      c         <= c_next;
      buffer_pc <= buffer_pc_next;
    end
  end

  // Pulses are combinational; gating with Reset keeps them low while reset is held.
  assign IntClk          = int_clk & Reset;
  assign IntHalt         = int_halt & Reset;
  assign QualInterrupcao = {30'd0, cause};
  assign BufferPC        = buffer_pc;
  assign Ativo           = (state == ST_RUN);

`ifdef INT_STATS_EN
  logic [15:0] int_count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      int_count <= '0;
    end else if (int_clk && int_count != 16'hFFFF) begin
      int_count <= int_count + 16'd1;
    end
  end

  assign ContagemInterrupcoes = int_count;
`else
  assign ContagemInterrupcoes = '0;
`endif

endmodule

// File: tb/tb_escalonador_quantum.sv
// Self-checking bench for escalonador_quantum: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a quantum-elapsed behavioural model.
module tb_escalonador_quantum;

`ifdef INT_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Halt = 1'b0;
  logic        SetClock = 1'b0;
  logic [15:0] TempoQuantum = '0;
  logic        GetInterruption = 1'b0;
  logic [10:0] PCAtual = '0;
  logic [10:0] PCProximo = '0;
  logic        IntClk, IntHalt, Ativo;
  logic [31:0] QualInterrupcao;
  logic [10:0] BufferPC;
  logic [15:0] ContagemInterrupcoes;

  int n_checks = 0;
  int n_fail   = 0;

  escalonador_quantum dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .Halt                (Halt),
    .SetClock            (SetClock),
    .TempoQuantum        (TempoQuantum),
    .GetInterruption     (GetInterruption),
    .PCAtual             (PCAtual),
    .PCProximo           (PCProximo),
    .IntClk              (IntClk),
    .IntHalt             (IntHalt),
    .QualInterrupcao     (QualInterrupcao),
    .BufferPC            (BufferPC),
    .Ativo               (Ativo),
    .ContagemInterrupcoes(ContagemInterrupcoes)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a process is running or pending; expiry happens on the
  // Q-th user-mode cycle since the quantum was (re)started.
  bit          m_run, m_pend;
  int          m_q, m_elapsed, m_cause, m_cnt;
  logic [10:0] m_buf;
  bit          e_clk, e_halt;
  int          nq;

  initial begin
    m_run = 0; m_pend = 0; m_q = 0; m_elapsed = 0; m_cause = 0; m_cnt = 0; m_buf = '0;
  end

  always @(negedge Clock) begin
    if (!Reset) begin
      check("rst_intclk", IntClk, 0);
      check("rst_inthalt", IntHalt, 0);
      check("rst_cause", QualInterrupcao, 0);
      check("rst_bufpc", BufferPC, 0);
      check("rst_ativo", Ativo, 0);
      check("rst_count", ContagemInterrupcoes, 0);
      m_run = 0; m_pend = 0; m_q = 0; m_elapsed = 0; m_cause = 0; m_cnt = 0; m_buf = '0;
    end else begin
      check("cause", QualInterrupcao, m_cause);
      check("bufpc", BufferPC, m_buf);
      check("ativo", Ativo, m_run);
      check("count", ContagemInterrupcoes, STATS_EN ? m_cnt : 0);

      e_clk  = 0;
      e_halt = 0;
      nq     = SetClock ? int'(TempoQuantum) : m_q;
      if (!m_pend) begin
        if (Halt) begin
          e_halt = 1; m_cause = 2; m_pend = 1; m_run = 0;
        end else if (SetClock) begin
          m_run = (TempoQuantum != 0); m_elapsed = 0;
        end else if (m_run && PCAtual >= 64) begin
          if (m_elapsed + 1 == m_q) begin
            e_clk = 1; m_buf = PCProximo; m_cause = 1; m_pend = 1; m_run = 0;
            if (m_cnt < 65535) m_cnt++;
          end else begin
            m_elapsed++;
          end
        end
      end else begin
        if (Halt) begin
          e_halt = 1; m_cause = 2;
        end else if (GetInterruption) begin
          m_cause = 0; m_pend = 0; m_run = (nq != 0); m_elapsed = 0;
        end
      end
      m_q = nq;

      check("intclk", IntClk, e_clk);
      check("inthalt", IntHalt, e_halt);
      check("pulse_exclusive", IntClk & IntHalt, 0);
    end
  end

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  // Steps cycles until IntClk is seen; lat = cycles after the caller's cycle, -1 if none within limit.
  task automatic run_until_clk(input int kernel_cycles, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      next_cycle();
      SetClock        = 1'b0;
      GetInterruption = 1'b0;
      PCAtual         = (i <= kernel_cycles) ? 11'd10 : 11'd100;
      #2;
      if (IntClk === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    next_cycle();
    #2;
    check("lit_rst_ativo", Ativo, 0);
    check("lit_rst_cause", QualInterrupcao, 0);
    next_cycle();
    Reset = 1'b1;

    // Quantum 5 in user code: expiry exactly 5 cycles after load.
    next_cycle();
    SetClock = 1'b1; TempoQuantum = 16'd5; PCAtual = 11'd100; PCProximo = 11'h2A5;
    run_until_clk(0, 50, lat);
    check("lit_q5_latency", lat, 5);
    next_cycle();
    #2;
    check("lit_q5_cause", QualInterrupcao, 1);
    check("lit_q5_bufpc", BufferPC, 11'h2A5);
    check("lit_q5_ativo", Ativo, 0);

    // SetClock in PEND only updates Q; acknowledge restarts with Q=4.
    next_cycle();
    SetClock = 1'b1; TempoQuantum = 16'd4; PCProximo = 11'h155;
    next_cycle();
    SetClock = 1'b0; GetInterruption = 1'b1;
    #2;
    check("lit_pend_setclk_ativo", Ativo, 0);
    check("lit_pend_setclk_cause", QualInterrupcao, 1);
    run_until_clk(0, 50, lat);
    check("lit_ack_q4_latency", lat, 4);
    next_cycle();
    #2;
    check("lit_ack_q4_bufpc", BufferPC, 11'h155);

    // Acknowledge with Q=0 returns to IDLE and never fires.
    next_cycle();
    SetClock = 1'b1; TempoQuantum = 16'd0;
    next_cycle();
    SetClock = 1'b0; GetInterruption = 1'b1;
    next_cycle();
    GetInterruption = 1'b0;
    #2;
    check("lit_ack_q0_ativo", Ativo, 0);
    check("lit_ack_q0_cause", QualInterrupcao, 0);
    run_until_clk(0, 20, lat);
    check("lit_ack_q0_noclk", lat, -1);

    // Halt coinciding with expiry: halt wins, BufferPC untouched.
    next_cycle();
    SetClock = 1'b1; TempoQuantum = 16'd2; PCProximo = 11'h0FF;
    next_cycle();
    SetClock = 1'b0;
    #2;
    check("lit_c2_noclk", IntClk, 0);
    next_cycle();
    Halt = 1'b1;
    #2;
    check("lit_halt_wins_inthalt", IntHalt, 1);
    check("lit_halt_wins_intclk", IntClk, 0);
    next_cycle();
    Halt = 1'b0;
    #2;
    check("lit_halt_cause", QualInterrupcao, 2);
    check("lit_halt_bufpc", BufferPC, 11'h155);

    // Halt beats acknowledge in PEND.
    next_cycle();
    Halt = 1'b1; GetInterruption = 1'b1;
    #2;
    check("lit_pend_halt_pulse", IntHalt, 1);
    next_cycle();
    Halt = 1'b0; GetInterruption = 1'b0;
    #2;
    check("lit_pend_halt_ativo", Ativo, 0);
    check("lit_pend_halt_cause", QualInterrupcao, 2);
    next_cycle();
    GetInterruption = 1'b1;
    next_cycle();
    GetInterruption = 1'b0;
    #2;
    check("lit_ack_run_ativo", Ativo, 1);
    check("lit_ack_run_cause", QualInterrupcao, 0);

    // SetClock on the expiry cycle suppresses IntClk and reloads.
    next_cycle();
    SetClock = 1'b1; TempoQuantum = 16'd3;
    #2;
    check("lit_load_beats_expiry", IntClk, 0);
    run_until_clk(0, 50, lat);
    check("lit_reload_latency", lat, 3);

    // Reset during PEND cause 1 clears everything at once, even with Halt high.
    next_cycle();
    Reset = 1'b0; Halt = 1'b1;
    #2;
    check("lit_midrst_intclk", IntClk, 0);
    check("lit_midrst_inthalt", IntHalt, 0);
    check("lit_midrst_cause", QualInterrupcao, 0);
    check("lit_midrst_bufpc", BufferPC, 0);
    check("lit_midrst_ativo", Ativo, 0);
    next_cycle();
    Reset = 1'b1; Halt = 1'b0;
    run_until_clk(0, 10, lat);
    check("lit_after_rst_noclk", lat, -1);

    // Kernel code holds the counter: quantum 3 with 4 kernel cycles first.
    next_cycle();
    SetClock = 1'b1; TempoQuantum = 16'd3; PCAtual = 11'd10;
    run_until_clk(4, 50, lat);
    check("lit_kernel_hold_latency", lat, 7);

    // Three clock expiries from a fresh reset.
    next_cycle();
    Reset = 1'b0;
    next_cycle();
    Reset = 1'b1;
    next_cycle();
    SetClock = 1'b1; TempoQuantum = 16'd2;
    run_until_clk(0, 20, lat);
    check("lit_stats_lat0", lat, 2);
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      GetInterruption = 1'b1;
      run_until_clk(0, 20, lat);
      check("lit_stats_lat", lat, 2);
    end
    next_cycle();
    #2;
    check("lit_stats_count", ContagemInterrupcoes, STATS_EN ? 3 : 0);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      Reset           = ($urandom_range(0, 199) != 0);
      Halt            = ($urandom_range(0, 15) == 0);
      SetClock        = ($urandom_range(0, 9) == 0);
      TempoQuantum    = 16'($urandom_range(0, 6));
      GetInterruption = ($urandom_range(0, 5) == 0);
      PCAtual         = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 63))
                                                    : 11'($urandom_range(64, 2047));
      PCProximo       = 11'($urandom_range(0, 2047));
    end

    next_cycle();
    Reset = 1'b1; Halt = 1'b0; SetClock = 1'b0; GetInterruption = 1'b0;
    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
